// File: rtl/uart_rx_to_ram.sv
// 8N1 UART receiver that pairs bytes into 16-bit words (high byte first) and
// writes them to consecutive RAM addresses until WORD_COUNT words are loaded.
module uart_rx_to_ram #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned WORD_COUNT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              enable_to_ram,
  output logic              write_enable_to_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic [DATA_W-1:0] data_to_ram,
  output logic              busy,
  output logic              load_done,
  output logic              frame_error
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0]   CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]   CntFull  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORD_COUNT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

  state_e            state_q;
  logic              rx_meta_q, rx_s;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        idx_q;
  logic [7:0]        shift_q;
  logic              byte_valid_q;
  logic              byte_discard_q;
  logic              byte_phase_q;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] word_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      busy           <= 1'b0;
      frame_error    <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_discard_q <= 1'b0;
    end else begin
      byte_valid_q   <= 1'b0;
      byte_discard_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= StData;
              idx_q   <= '0;
            end else begin
              // Too short to be a start bit: treat as line noise.
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CntFull) begin
            cnt_q <= '0;
            if (rx_s) begin
              byte_valid_q <= 1'b1;
              state_q      <= StIdle;
              busy         <= 1'b0;
            end else begin
              frame_error    <= 1'b1;
              byte_discard_q <= 1'b1;
              state_q        <= StWaitIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitIdle: begin
          if (rx_s) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_phase_q        <= 1'b0;
      hi_q                <= '0;
      word_addr_q         <= '0;
      enable_to_ram       <= 1'b0;
      write_enable_to_ram <= 1'b0;
      address_to_ram      <= '0;
      data_to_ram         <= '0;
      load_done           <= 1'b0;
    end else begin
      enable_to_ram       <= 1'b0;
      write_enable_to_ram <= 1'b0;
      // Address advances after the strobe, but stops at the last word.
      if (enable_to_ram && word_addr_q != LastAddr) word_addr_q <= word_addr_q + 1'b1;
      if (byte_discard_q) begin
        byte_phase_q <= 1'b0;
      end else if (byte_valid_q) begin
        if (!byte_phase_q) begin
          hi_q         <= shift_q;
          byte_phase_q <= 1'b1;
        end else begin
          byte_phase_q <= 1'b0;
          if (!load_done) begin
            enable_to_ram       <= 1'b1;
            write_enable_to_ram <= 1'b1;
            address_to_ram      <= word_addr_q;
            data_to_ram         <= {hi_q, shift_q};
            if (word_addr_q == LastAddr) load_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_to_ram.sv
// Scoreboard bench for uart_rx_to_ram: a byte-level model predicts RAM writes,
// a monitor pops and compares each observed write strobe.
module tb_uart_rx_to_ram;
  localparam int unsigned Cpb = 8;
  localparam int unsigned Wc  = 4;
  localparam int unsigned Aw  = 6;
  localparam int unsigned Dw  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          uart_rx = 1'b1;
  logic          enable_to_ram, write_enable_to_ram, busy, load_done, frame_error;
  logic [Aw-1:0] address_to_ram;
  logic [Dw-1:0] data_to_ram;

  uart_rx_to_ram #(
    .CLKS_PER_BIT(Cpb),
    .ADDR_W      (Aw),
    .DATA_W      (Dw),
    .WORD_COUNT  (Wc)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .uart_rx            (uart_rx),
    .enable_to_ram      (enable_to_ram),
    .write_enable_to_ram(write_enable_to_ram),
    .address_to_ram     (address_to_ram),
    .data_to_ram        (data_to_ram),
    .busy               (busy),
    .load_done          (load_done),
    .frame_error        (frame_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected write: {address, data, load_done}
  logic [Aw+Dw:0] exp_q[$];

  // Behavioural model state
  int         m_phase;
  logic [7:0] m_hi;
  int         m_addr;
  bit         m_done;
  bit         m_fe;

  task automatic model_reset();
    m_phase = 0; m_hi = '0; m_addr = 0; m_done = 0; m_fe = 0;
    exp_q.delete();
  endtask

  task automatic model_good(input logic [7:0] b);
    logic [Aw-1:0] a;
    if (m_phase == 0) begin
      m_hi = b;
      m_phase = 1;
    end else begin
      m_phase = 0;
      if (!m_done) begin
        a = Aw'(m_addr);
        exp_q.push_back({a, m_hi, b, (m_addr == Wc - 1) ? 1'b1 : 1'b0});
        if (m_addr == Wc - 1) m_done = 1;
        else m_addr++;
      end
    end
  endtask

  task automatic model_bad();
    m_phase = 0;
    m_fe = 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && enable_to_ram) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%04h, no write expected",
                 address_to_ram, data_to_ram);
      end else begin
        logic [Aw+Dw:0] e;
        e = exp_q.pop_front();
        if ({address_to_ram, data_to_ram, load_done} !== e || write_enable_to_ram !== 1'b1) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%04h done=%0b wea=%0b expected addr=%0d data=%04h done=%0b wea=1",
                   address_to_ram, data_to_ram, load_done, write_enable_to_ram,
                   e[Aw+Dw:Dw+1], e[Dw:1], e[0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    uart_rx = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_outputs",
          {26'(0), enable_to_ram, write_enable_to_ram, busy, load_done, frame_error, 1'b0},
          32'd0);
    check("reset_addr_data", {10'(0), address_to_ram, data_to_ram}, 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(2);
  endtask

  // Drives one frame; extra_low holds the line low after a bad stop bit.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int extra_low);
    uart_rx = 1'b0;
    cyc(Cpb);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (i == 4) begin
        @(negedge clk);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        cyc(Cpb - 1);
      end else begin
        cyc(Cpb);
      end
    end
    if (stop_ok) model_good(b);
    else model_bad();
    uart_rx = stop_ok;
    cyc(Cpb);
    if (!stop_ok) cyc(extra_low);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single word
    send_byte(8'h12, 1, 0);
    send_byte(8'h34, 1, 0);
    cyc(4);
    check("t1_written", exp_q.size(), 0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_not_done", {31'd0, load_done}, 32'd0);

    // Back-to-back fill to load_done, then one more byte
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1, 0);
    cyc(4);
    check("t2_done", {31'd0, load_done}, 32'd1);
    send_byte(8'h99, 1, 0);
    cyc(4);
    check("t2_written", exp_q.size(), 0);
    check("t2_done_sticky", {31'd0, load_done}, 32'd1);

    // Short glitch
    do_reset();
    uart_rx = 1'b0;
    cyc(2);
    uart_rx = 1'b1;
    cyc(20);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_fe", {31'd0, frame_error}, 32'd0);

    // Framing error with a long break
    send_byte(8'hAA, 0, 20);
    @(negedge clk);
    check("break_busy_held", {31'd0, busy}, 32'd1);
    check("break_fe", {31'd0, frame_error}, 32'd1);
    uart_rx = 1'b1;
    cyc(6);
    check("break_busy_release", {31'd0, busy}, 32'd0);
    send_byte(8'hAB, 1, 0);
    send_byte(8'hCD, 1, 0);
    cyc(4);
    check("t4_written", exp_q.size(), 0);
    check("t4_fe_sticky", {31'd0, frame_error}, 32'd1);

    // Reset in the middle of the second byte
    do_reset();
    send_byte(8'h55, 1, 0);
    uart_rx = 1'b0;
    cyc(Cpb);
    uart_rx = 1'b1;
    cyc(3 * Cpb);
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    do_reset();
    send_byte(8'h9A, 1, 0);
    send_byte(8'hBC, 1, 0);
    cyc(4);
    check("t5_written", exp_q.size(), 0);

    // Randomised frames with occasional framing errors and gaps
    do_reset();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 6) != 0);
      send_byte(b, ok, ok ? 0 : $urandom_range(0, 12));
      uart_rx = 1'b1;
      cyc(ok ? $urandom_range(0, 3) : $urandom_range(2, 5));
    end
    cyc(20);
    check("rand_written", exp_q.size(), 0);
    check("rand_fe", {31'd0, frame_error}, {31'd0, m_fe});
    check("rand_done", {31'd0, load_done}, {31'd0, m_done});
    check("rand_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
